alu_md: RTL and testbench
=========================

Name:
alu_md

Overview:
- Parametrised-width successor to the single-cycle integer ALU, sitting in the CPU execute stage.
- Adds signed and unsigned SLT, an iterative multiply/divide unit with HI/LO registers, and a valid/ready operand handshake.
- Single-cycle ops return one clock after acceptance. MULT/DIV stall the issuing stage through in_ready until complete.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two, minimum 8.
- Derived localparam SHW = $clog2(WIDTH), the shift-amount width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands and op presented
- in_ready  output  1  unit can accept (state IDLE)
- alu_ctrl  input  4  operation select
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B / shift amount
- out_valid  output  1  one-cycle pulse, result valid
- alu_result  output  WIDTH  registered result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- zero  output  1  alu_result == 0
- positive  output  1  alu_result > 0, signed
- negative  output  1  alu_result[WIDTH-1]
- err  output  1  with out_valid: unsupported op

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, in_ready=1, out_valid=0, alu_result=0, hi=0, lo=0, err=0. zero, positive and negative follow alu_result, so after reset zero=1, positive=0, negative=0.
- Accept: on a rising edge with in_valid && in_ready. Operands and op are latched; src_* may change afterwards.
- Opcodes:
  - 0000 SLTU: unsigned A<B.
  - 0001 ADD, 0010 SUB: wrap modulo 2^WIDTH, no overflow flag.
  - 0011 AND, 0100 OR, 0101 XOR, 1011 NOR.
  - 0110 SLT: signed A<B; result is 0 or 1, zero-extended.
  - 0111 LUI: {B[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 1000 SLL, 1001 SRL, 1010 SRA: shift amount is B[SHW-1:0]; SRA is arithmetic.
  - 1100 MULT, 1101 MULTU, 1110 DIV, 1111 DIVU.
- Single-cycle ops:
  - alu_result and out_valid=1 register on the acceptance edge, so the result is visible one clock later.
  - in_ready stays 1, so a new op may be accepted every cycle.
  - hi and lo are unchanged.
- FSM states are IDLE, BUSY and FIN.
  - IDLE -> BUSY on accepting 11xx. Operand magnitudes and the result sign are captured; the cycle counter is cleared; in_ready drops.
  - BUSY: one shift-add (MULT) or restoring-subtract (DIV) step per clock. After WIDTH steps -> FIN.
  - FIN, one clock: apply the sign fix-up and write hi/lo. Set alu_result=lo and out_valid=1, then -> IDLE.
  - out_valid therefore appears WIDTH+2 clocks after the acceptance edge. in_ready returns to 1 in the same cycle.
- Multiply: hi:lo holds the full 2*WIDTH product, signed (MULT) or unsigned (MULTU).
- Divide:
  - lo holds the quotient, truncated toward zero.
  - hi holds the remainder, which takes the dividend's sign.
  - Divide by zero: lo = all ones, hi = dividend. err=0.
  - Signed overflow DIV MIN/-1: lo = MIN, hi = 0.
- in_valid while in_ready=0 is ignored; the producer must hold the op.
- Reset mid-operation: abandon the operation immediately and clear all state. No out_valid is produced, and hi/lo read 0.
- out_valid is never high for more than one cycle per accepted op.

Optional Feature:
- Macro: ALU_MD_DIV_EN.
- Defined: DIV and DIVU run as specified above.
- Undefined:
  - DIV/DIVU complete as single-cycle ops: alu_result=0, err=1 with out_valid, hi/lo unchanged.
  - No divider datapath is built. MULT/MULTU are unaffected.

Test Plan:
- Back-to-back ADD then SUB, WIDTH=32:
  - ADD 0xFFFFFFFF + 1, accepted on consecutive edges -> alu_result=0, zero=1 one clock after accept.
  - SUB 3 - 5 -> alu_result=0xFFFFFFFE, negative=1 the following cycle.
  - in_ready=1 throughout.
- SLT vs SLTU, A=0xFFFFFFFF, B=1 -> SLT result 1, SLTU result 0. SRA 0x80000000 by 4 -> 0xF8000000.
- MULT -3 x 5 -> in_ready=0 for 33 cycles; out_valid 34 clocks after accept; hi=0xFFFFFFFF, lo=0xFFFFFFF1, alu_result=lo, negative=1.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 9 / 0 -> lo=0xFFFFFFFF, hi=9. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0. If ALU_MD_DIV_EN is undefined: err=1, result 0, one-clock latency.
- rst asserted 10 cycles into a MULTU -> next cycle in_ready=1, hi=lo=0, and no out_valid ever.
- in_valid held high during BUSY with a different op -> ignored; that op is accepted on the cycle in_ready returns and completes with correct results.

Source files
------------

// File: rtl/alu_md.sv
// Execute-stage integer ALU with iterative multiply/divide and HI/LO registers; DIV/DIVU need ALU_MD_DIV_EN.
// Latency: single-cycle ops 1 clock after accept; MULT/DIV raise out_valid WIDTH+2 clocks after accept.
// Backpressure: in_ready=0 while a multiply/divide is in flight; in_valid is ignored until in_ready returns.
module alu_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             positive,
    output logic             negative,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]         state;
    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               neg_q;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_err;
    logic               accept;
    logic               start_md;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;
`ifdef ALU_MD_DIV_EN
    logic               div_q;
    logic               rneg_q;
    logic               dz_q;
    logic [WIDTH-1:0]   dividend_q;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH:0]     div_trial;
`endif

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
`ifdef ALU_MD_DIV_EN
    assign start_md  = accept && (alu_ctrl[3:2] == 2'b11);
`else
    assign start_md  = accept && (alu_ctrl[3:1] == 3'b110);
`endif
    assign op_signed = !alu_ctrl[0];
    assign a_neg     = op_signed && src_a[WIDTH-1];
    assign b_neg     = op_signed && src_b[WIDTH-1];
    assign mag_a     = a_neg ? -src_a : src_a;
    assign mag_b     = b_neg ? -src_b : src_b;

    assign zero     = (alu_result == '0);
    assign negative = alu_result[WIDTH-1];
    assign positive = !alu_result[WIDTH-1] && (alu_result != '0);

    always_comb begin
        sc_res = '0;
        sc_err = 1'b0;
        case (alu_ctrl)
            4'b0000: sc_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            4'b0001: sc_res = src_a + src_b;
            4'b0010: sc_res = src_a - src_b;
            4'b0011: sc_res = src_a & src_b;
            4'b0100: sc_res = src_a | src_b;
            4'b0101: sc_res = src_a ^ src_b;
            4'b0110: sc_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b0111: sc_res = {src_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            4'b1000: sc_res = src_a << src_b[SHW-1:0];
            4'b1001: sc_res = src_a >> src_b[SHW-1:0];
            4'b1010: sc_res = $signed(src_a) >>> src_b[SHW-1:0];
            4'b1011: sc_res = ~(src_a | src_b);
            // Only reachable for DIV/DIVU when the divider is not built.
            default: sc_err = 1'b1;
        endcase
    end

    // Multiplier: acc_lo starts as the multiplier and is shifted out as the product shifts in.
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
`ifdef ALU_MD_DIV_EN
    // Restoring divider: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};
    assign quo_fix   = neg_q ? -acc_lo : acc_lo;
    assign rem_fix   = rneg_q ? -acc_hi : acc_hi;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            opnd       <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            neg_q      <= 1'b0;
            alu_result <= '0;
            hi         <= '0;
            lo         <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
`ifdef ALU_MD_DIV_EN
            div_q      <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            dividend_q <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_md) begin
                        state  <= BUSY;
                        cnt    <= '0;
                        acc_hi <= '0;
                        neg_q  <= a_neg ^ b_neg;
`ifdef ALU_MD_DIV_EN
                        opnd       <= alu_ctrl[1] ? mag_b : mag_a;
                        acc_lo     <= alu_ctrl[1] ? mag_a : mag_b;
                        div_q      <= alu_ctrl[1];
                        rneg_q     <= a_neg;
                        dz_q       <= (src_b == '0);
                        dividend_q <= src_a;
`else
                        opnd   <= mag_a;
                        acc_lo <= mag_b;
`endif
                    end else if (accept) begin
                        alu_result <= sc_res;
                        err        <= sc_err;
                        out_valid  <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH-1)) begin
                        state <= FIN;
                    end
`ifdef ALU_MD_DIV_EN
                    if (div_q) begin
                        if (!div_trial[WIDTH]) begin
                            acc_hi <= div_trial[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
`else
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
`endif
                end
                FIN: begin
                    state     <= IDLE;
                    out_valid <= 1'b1;
                    err       <= 1'b0;
`ifdef ALU_MD_DIV_EN
                    if (div_q && dz_q) begin
                        lo         <= '1;
                        hi         <= dividend_q;
                        alu_result <= '1;
                    end else if (div_q) begin
                        lo         <= quo_fix;
                        hi         <= rem_fix;
                        alu_result <= quo_fix;
                    end else begin
                        hi         <= prod_fix[2*WIDTH-1:WIDTH];
                        lo         <= prod_fix[WIDTH-1:0];
                        alu_result <= prod_fix[WIDTH-1:0];
                    end
`else
                    hi         <= prod_fix[2*WIDTH-1:WIDTH];
                    lo         <= prod_fix[WIDTH-1:0];
                    alu_result <= prod_fix[WIDTH-1:0];
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md.sv
// Randomized scoreboard bench for alu_md against an arithmetic reference model.
module tb_alu_md;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [3:0]   alu_ctrl = '0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         in_ready, out_valid, zero, positive, negative, err;
    logic [W-1:0] alu_result, hi, lo;

    alu_md #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .alu_result(alu_result), .hi(hi), .lo(lo),
        .zero(zero), .positive(positive), .negative(negative), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         err;
        int           acc;
        int           lat;
    } exp_t;

    exp_t         sb_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: updates the architectural HI/LO copy in issue order.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [4:0]  sh;
        logic [63:0] p;
        int          sa, sb;
        sh    = b[4:0];
        sa    = $signed(a);
        sb    = $signed(b);
        p     = '0;
        e.res = '0;
        e.err = 1'b0;
        e.acc = 0;
        e.lat = 1;
        case (op)
            4'd0:  e.res = (a < b) ? 32'd1 : 32'd0;
            4'd1:  e.res = a + b;
            4'd2:  e.res = a - b;
            4'd3:  e.res = a & b;
            4'd4:  e.res = a | b;
            4'd5:  e.res = a ^ b;
            4'd6:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  e.res = b << 16;
            4'd8:  e.res = a << sh;
            4'd9:  e.res = a >> sh;
            4'd10: e.res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd11: e.res = ~(a | b);
            4'd12, 4'd13: begin
                if (op == 4'd12) p = longint'(sa) * longint'(sb);
                else             p = {32'd0, a} * {32'd0, b};
                mhi   = p[63:32];
                mlo   = p[31:0];
                e.res = mlo;
                e.lat = W + 2;
            end
            default: begin
`ifdef ALU_MD_DIV_EN
                if (b == '0) begin
                    mlo = '1;
                    mhi = a;
                end else if (op == 4'd14 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    mlo = a;
                    mhi = '0;
                end else if (op == 4'd14) begin
                    mlo = sa / sb;
                    mhi = sa % sb;
                end else begin
                    mlo = a / b;
                    mhi = a % b;
                end
                e.res = mlo;
                e.lat = W + 2;
`else
                e.res = '0;
                e.err = 1'b1;
`endif
            end
        endcase
        e.hi = mhi;
        e.lo = mlo;
        return e;
    endfunction

    // Monitor: every out_valid pulse must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result",   64'(alu_result), 64'(mon_e.res));
                chk("hi",       64'(hi),         64'(mon_e.hi));
                chk("lo",       64'(lo),         64'(mon_e.lo));
                chk("err",      64'(err),        64'(mon_e.err));
                chk("zero",     64'(zero),       64'(mon_e.res == '0));
                chk("negative", 64'(negative),   64'(mon_e.res[W-1]));
                chk("positive", 64'(positive),   64'($signed(mon_e.res) > 0));
                chk("latency",  64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
            end
        end
    end

    // Call at a stable point (#1 after posedge or at negedge); returns #1 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   guard = 0;
        in_valid = 1'b1;
        alu_ctrl = op;
        src_a    = a;
        src_b    = b;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e     = model(op, a, b);
        e.acc = cyc;
        sb_q.push_back(e);
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((sb_q.size() != 0 || !in_ready) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),   64'd1);
        chk("rst_out_valid", 64'(out_valid),  64'd0);
        chk("rst_result",    64'(alu_result), 64'd0);
        chk("rst_hi",        64'(hi),         64'd0);
        chk("rst_lo",        64'(lo),         64'd0);
        chk("rst_err",       64'(err),        64'd0);
        chk("rst_zero",      64'(zero),       64'd1);
        chk("rst_positive",  64'(positive),   64'd0);
        chk("rst_negative",  64'(negative),   64'd0);
        @(posedge clk);
        #1;

        issue(4'd1, 32'hFFFF_FFFF, 32'd1);
        chk("b2b_ready_add", 64'(in_ready), 64'd1);
        issue(4'd2, 32'd3, 32'd5);
        chk("b2b_ready_sub", 64'(in_ready), 64'd1);
        issue(4'd6, 32'hFFFF_FFFF, 32'd1);
        issue(4'd0, 32'hFFFF_FFFF, 32'd1);
        issue(4'd10, 32'h8000_0000, 32'd4);
        issue(4'd7, 32'd0, 32'h1234_ABCD);

        issue(4'd12, 32'hFFFF_FFFD, 32'd5);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        chk("mult_busy_cycles", 64'(n), 64'd33);
        chk("mult_out_valid",   64'(out_valid), 64'd1);
        chk("mult_hi",          64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo",          64'(lo), 64'hFFFF_FFF1);

        issue(4'd14, 32'hFFFF_FFF9, 32'd2);
        issue(4'd15, 32'd9, 32'd0);
        issue(4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
`ifdef ALU_MD_DIV_EN
        chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(hi), 64'd0);
`else
        chk("nodiv_lo", 64'(lo), 64'hFFFF_FFF1);
        chk("nodiv_hi", 64'(hi), 64'hFFFF_FFFF);
`endif

        // A different op held on in_valid through BUSY must wait for in_ready.
        issue(4'd13, $urandom, $urandom);
        issue(4'd5, $urandom, $urandom);
        wait_idle();

        issue(4'd13, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        chk("midrst_hi",        64'(hi),        64'd0);
        chk("midrst_lo",        64'(lo),        64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        repeat (50) @(negedge clk);
        @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            issue(4'($urandom_range(0, 15)), pick(), pick());
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
